// File: rtl/sudoku_pkg.sv
// sudoku_pkg: result codes, move-checker FSM states and board cell addressing
package sudoku_pkg;
   localparam logic [1:0] RES_OK = 2'b00, RES_FIM = 2'b01, RES_CONF = 2'b10, RES_INV = 2'b11;
   typedef enum logic [1:0] {IDLE, LOAD, SCAN, FINISH} estado_t;
   function automatic int idx(input int r, input int c, input int n, input int w);
      return (r * n + c) * w;
   endfunction
endpackage

// File: rtl/sudoku_conflito_celula.sv
// sudoku_conflito_celula: classifies scanned cell k against the move (row/column/box clash, emptiness)
module sudoku_conflito_celula #(
   parameter int BLOCO = 3,
   parameter int W = 4,
   parameter int KW = 7
) (
   input  logic [KW-1:0] k,
   input  logic [W-1:0]  linha,
   input  logic [W-1:0]  coluna,
   input  logic [W-1:0]  cel,
   input  logic [W-1:0]  valor,
   input  logic          modo,
   output logic          conflito,
   output logic          vazio
);
   localparam int N = BLOCO * BLOCO;
   int r, c, tr, tc;
   logic mesma;
   always_comb begin
      r = int'(k) / N;
      c = int'(k) % N;
      tr = int'(linha) - 1;
      tc = int'(coluna) - 1;
      mesma = r == tr || c == tc || (r / BLOCO == tr / BLOCO && c / BLOCO == tc / BLOCO);
      conflito = !modo && !(r == tr && c == tc) && cel == valor && mesma;
      vazio = cel == '0;
   end
endmodule

// File: rtl/verifica_jogada_param.sv
// verifica_jogada_param: inserts one value into an NxN board, then scans it cell by cell
// for rule conflicts (or checks the solution board) and reports completion.
module verifica_jogada_param import sudoku_pkg::*; #(
   parameter int BLOCO = 3,
   parameter int W = 4,
   localparam int N = BLOCO * BLOCO,
   localparam int GRID = N * N * W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    linha,
   input  logic [W-1:0]    coluna,
   input  logic [W-1:0]    valor,
   input  logic            modo,
   input  logic [0:GRID-1] sudoku_jogador,
   input  logic [0:GRID-1] sudoku_gabarito,
   output logic [0:GRID-1] novo_sudoku,
   output logic            we_sudoku,
   output logic            busy,
   output logic            done,
   output logic [1:0]      resultado,
   output logic [W-1:0]    conf_linha,
   output logic [W-1:0]    conf_coluna
);
   localparam int KW = $clog2(N * N);
   estado_t st, st_n;
   logic [W-1:0] lin, col, val, cel;
   logic mod, vazio, ilegal, erro, ult, conflito, vz;
   logic [0:GRID-1] buff;
   logic [KW-1:0] k;
   int tgt;
   sudoku_conflito_celula #(.BLOCO(BLOCO), .W(W), .KW(KW)) u_cel (
      .k(k), .linha(lin), .coluna(col), .cel(cel), .valor(val), .modo(mod),
      .conflito(conflito), .vazio(vz)
   );
   always_comb begin
      st_n = st;
      tgt = idx(int'(lin) - 1, int'(col) - 1, N, W);
      cel = buff[int'(k) * W +: W];
      ilegal = lin == '0 || int'(lin) > N || col == '0 || int'(col) > N ||
               val == '0 || int'(val) > N || buff[tgt +: W] != '0;
      erro = mod && sudoku_gabarito[tgt +: W] != val;
      ult = k == KW'(N * N - 1);
      unique case (st)
         IDLE:   st_n = start ? LOAD : IDLE;
         LOAD:   st_n = (ilegal || erro) ? FINISH : SCAN;
         SCAN:   st_n = (conflito || ult) ? FINISH : SCAN;
         FINISH: st_n = IDLE;
      endcase
   end
   // A rejected move clears its target again, so the buffer always equals the board to publish
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         lin <= '0;
         col <= '0;
         val <= '0;
         mod <= 1'b0;
         buff <= '0;
         k <= '0;
         vazio <= 1'b0;
         resultado <= RES_OK;
         conf_linha <= '0;
         conf_coluna <= '0;
      end else begin
         st <= st_n;
         unique case (st)
            IDLE: if (start) begin
               lin <= linha;
               col <= coluna;
               val <= valor;
               mod <= modo;
               buff <= sudoku_jogador;
               k <= '0;
               vazio <= 1'b0;
               resultado <= RES_OK;
               conf_linha <= '0;
               conf_coluna <= '0;
            end
            LOAD: begin
               k <= '0;
               if (ilegal) resultado <= RES_INV;
               else if (erro) begin
                  resultado <= RES_CONF;
                  conf_linha <= lin;
                  conf_coluna <= col;
               end else buff[tgt +: W] <= val;
            end
            SCAN: if (conflito) begin
               resultado <= RES_CONF;
               conf_linha <= W'(int'(k) / N + 1);
               conf_coluna <= W'(int'(k) % N + 1);
               buff[tgt +: W] <= '0;
            end else begin
               vazio <= vazio | vz;
               if (ult) resultado <= (vazio | vz) ? RES_OK : RES_FIM;
               else k <= k + 1'b1;
            end
            FINISH: ;
         endcase
      end
   end
   assign novo_sudoku = buff;
   assign busy = st != IDLE;
   assign done = st == FINISH;
   assign we_sudoku = done && !resultado[1];
endmodule

// File: doc/verifica_jogada_param.md
Name: verifica_jogada_param

Overview:
- Parametrised, multi-cycle successor to the move checker.
- Inserts one value into an N×N Sudoku board, where N = BLOCO².
- Scans the whole board one cell per cycle for row, column and box conflicts, or checks the value against the solution board, and detects a completed board.
- Sits between the input-register FSM (row/column/value registers) and the board register; returns a result code to the game-control FSM through a start/done handshake.

Parameters:
- BLOCO, 3, box side; N = BLOCO*BLOCO cells per row, column and box.
- W, 4, bits per cell; must satisfy 2^W > N; value 0 means an empty cell.
- GRID, N*N*W (localparam), board vector width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- linha  in  W  row of the move, 1-based.
- coluna  in  W  column of the move, 1-based.
- valor  in  W  value to insert, 1..N.
- modo  in  1  0 = rule check (row/column/box), 1 = compare against the solution board.
- sudoku_jogador  in  GRID  current board, ascending [0:GRID-1]; cell (r,c), 0-based, occupies [(r*N+c)*W +: W], MSB first.
- sudoku_gabarito  in  GRID  solution board, same layout.
- novo_sudoku  out  GRID  board with the move applied.
- we_sudoku  out  1  one-cycle write strobe to the board register.
- busy  out  1  high from LOAD through FINISH.
- done  out  1  one-cycle completion pulse.
- resultado  out  2  00 valid and incomplete; 01 valid and complete; 10 conflict; 11 illegal input.
- conf_linha, conf_coluna  out  W  1-based position of the first conflicting cell; 0 if there is none.

Behaviour:
Reset and idle:
- rst (synchronous) forces IDLE and clears every output and the internal buffer to 0. This applies mid-operation as well; no write strobe is issued for an aborted move.
- FSM states are IDLE, LOAD, SCAN, FINISH.

IDLE:
- On start=1, latch linha, coluna, valor, modo and sudoku_jogador, then go to LOAD.
- start while busy is ignored; inputs may change after the latch edge.

LOAD (1 cycle):
- Illegal input: linha or coluna is 0 or >N, valor is 0 or >N, or the target cell is already nonzero. Result is 11; go to FINISH without scanning.
- Otherwise write valor into the buffer at the target cell and clear counter k.
- If modo=1 and gabarito(target) != valor: record conflict at the target cell, result 10, go to FINISH.
- Otherwise go to SCAN.

SCAN (one cell k per cycle, k = 0..N*N-1, r = k/N, c = k%N):
- Conflict when all of the following hold:
  - modo=0;
  - k is not the target;
  - buf[k] == valor;
  - the cell shares a row, a column, or a box with the target. Box test: r/BLOCO == (linha-1)/BLOCO and c/BLOCO == (coluna-1)/BLOCO.
- On conflict: store (r+1, c+1) in conf_linha/conf_coluna, result 10, go to FINISH immediately (early exit).
- Otherwise set a sticky `vazio` flag if buf[k]==0.
- At k = N*N-1 with no conflict: result is 01 if vazio==0, else 00; go to FINISH.
- Counter k is ceil(log2(N*N)) bits and never wraps past N*N-1.

FINISH (1 cycle):
- done=1 and resultado valid.
- we_sudoku=1 only for results 00/01; in the same cycle novo_sudoku = buffer.
- For results 10/11, novo_sudoku = latched sudoku_jogador and we_sudoku=0.
- resultado, conf_* and novo_sudoku hold until the next start is accepted.
- Return to IDLE.

Latency (start-accept edge = cycle 0, N=9):
- Legal, conflict-free move: done in cycle N*N+2 = 83.
- Conflict at scan index k: done in cycle k+3.
- Solution-board mismatch or illegal input: done in cycle 2.

Other rules:
- busy=0 only in IDLE; start in the same cycle as done is not accepted.
- Box and index arithmetic is done in integer/unsigned width ≥ ceil(log2(GRID)); no truncation to W bits.

Decomposition:
- Package sudoku_pkg holds:
  - result codes RES_OK=2'b00, RES_FIM=2'b01, RES_CONF=2'b10, RES_INV=2'b11;
  - state encodings IDLE/LOAD/SCAN/FINISH;
  - a cell-offset function idx(r,c,N,W).
- One combinational sub-module, sudoku_conflito_celula. Inputs: k, target row/column, buf[k], valor, modo. Outputs: conflito, vazio.

Test Plan:
- Empty board, move (1,1,5), modo=0 → done in cycle 83, resultado=00, we_sudoku=1, novo_sudoku[0:3]=4'd5, conf=(0,0).
- Board with 5 at (1,9), move (1,1,5) → row conflict found at k=8, done in cycle 11, resultado=10, conf=(1,9), we_sudoku=0.
- Board with 7 at (3,3) only, move (2,2,7) → box conflict, resultado=10, conf=(3,3); separately, 7 at (4,4) gives resultado=00 (different box).
- Complete valid board with (9,9) cleared, move (9,9,correct) → done in cycle 83, resultado=01.
- modo=1, gabarito(5,5)=3, move (5,5,4) → done in cycle 2, resultado=10, conf=(5,5); move (0,3,2) or valor=10 → resultado=11 in cycle 2.
- rst asserted in SCAN at k=40 → next cycle IDLE with all outputs 0 and no we_sudoku; start pulsed while busy → ignored.
- BLOCO=2 (N=4, W=3) build → empty-board move done in cycle 18; parameter sweep passes.
